grid_scan_driver: RTL and testbench
===================================

GRID_SCAN_DRIVER -- requirements
Module: grid_scan_driver

Interface
REQ-001 Parameter DWELL, default 1000: clock cycles each row is driven (legal range >= 1).
REQ-002 Parameter BLANK, default 8: all-off clock cycles before each row (legal range >= 0).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 en  in  1  scan enable.
REQ-006 grid_in  in  64  current generation, with grid_in[r*8+c] = cell (row r, column c).
REQ-007 gen_valid  in  1  one-cycle pulse: grid_in holds a new generation.
REQ-008 row_sel  out  8  one-hot row drive, active-high, bit r = row r.
REQ-009 col_data  out  8  column data for the driven row, bit c = column c.
REQ-010 frame_done  out  1  one-cycle pulse at the end of every completed 8-row frame.
REQ-011 dropped  out  1  sticky flag: a pending generation was overwritten before it was displayed.

Function
REQ-012 The block shall be double-buffered: a back buffer (64b) plus a pending bit, and a front buffer (64b) used for display.
REQ-013 The block shall register all outputs; row_sel and col_data shall change only on clock edges.
REQ-014 The scan FSM shall have two states, BLANK and DRIVE, plus a row index 0..7 and a cycle counter sized to hold max(DWELL, BLANK).
REQ-015 In BLANK, row_sel and col_data shall be 0 for exactly BLANK cycles, then the FSM shall enter DRIVE; if BLANK=0, BLANK shall be skipped.
REQ-016 In DRIVE, row_sel shall be the one-hot code of the row index and col_data shall be front[row*8 +: 8], for exactly DWELL cycles.
REQ-017 On leaving DRIVE with row < 7, the row index shall increment and the FSM shall enter BLANK (or DRIVE if BLANK=0).
REQ-018 On leaving DRIVE with row = 7, the row index shall wrap to 0 and frame_done shall pulse for one cycle; this edge is the swap edge.
REQ-019 Frame period shall be exactly 8*(BLANK+DWELL) cycles while en=1.
REQ-020 When gen_valid=1 and this is not a swap edge, back shall load grid_in and pending shall be set.
REQ-021 On a swap edge with pending=1 and gen_valid=0, front shall load back and pending shall clear.
REQ-022 On a swap edge with gen_valid=1, front shall load grid_in directly and pending shall clear, regardless of the prior pending value; this case shall not set dropped.
REQ-023 On a swap edge with pending=0 and gen_valid=0, front shall be unchanged.
REQ-024 If gen_valid=1 while pending=1 and the edge is not a swap edge, back shall be overwritten and dropped shall set and stay set until reset.
REQ-025 While en=0, the FSM shall be forced synchronously to BLANK with row 0 and counter 0, outputs shall be 0, and no frame_done shall be issued.
REQ-026 Buffer and pending logic shall operate independently of en.
REQ-027 When en rises, the scan shall restart from a full BLANK period for row 0.
REQ-028 row_sel shall never have more than one bit set in any cycle.

Reset
REQ-029 Reset shall asynchronously clear row_sel, col_data, frame_done, dropped, pending, both buffers, the row index and the counter, and shall place the FSM in BLANK.
REQ-030 Reset asserted mid-row shall blank outputs immediately, without waiting for a clock edge.
REQ-031 After reset deasserts with en=1, the first DRIVE cycle of row 0 shall occur BLANK cycles later.

Verification (DWELL=4, BLANK=2)
REQ-032 Scenario: reset, en=1, gen_valid pulse with grid_in=64'h0102040810204080 before the first swap -> the second frame drives row_sel=8'h01 with col_data=8'h80 through row_sel=8'h80 with col_data=8'h01; each row is driven 4 cycles after 2 blank cycles.
REQ-033 Scenario: count cycles between consecutive frame_done pulses -> exactly 48 cycles; exactly one pulse per frame.
REQ-034 Scenario: two gen_valid pulses (A then B) within one frame, not on the swap edge -> dropped=1, and the next frame shows B.
REQ-035 Scenario: gen_valid coincides with the swap edge while pending holds A, new data C -> the next frame shows C, pending=0, dropped=0.
REQ-036 Scenario: en dropped mid-row 3 for 5 cycles -> row_sel=0 and col_data=0 from the next edge; after en rises, 2 blank cycles, then row 0.
REQ-037 Scenario: rst asserted between clock edges during DRIVE -> row_sel=0, col_data=0 and dropped=0 immediately, and a blank display follows deassertion.

Source files
------------

// File: rtl/grid_scan_driver.sv
// Row-multiplexed 8x8 display driver: double-buffered grid, blank/drive row scan.
// States: BLANK | all outputs off between rows ; DRIVE | one row driven from front buffer
module grid_scan_driver #(
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] grid_in,
  input  logic        gen_valid,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic        dropped
);

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   front_q, front_d;
  logic [63:0]   back_q, back_d;
  logic          pending_q, pending_d;
  logic          dropped_q, dropped_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic [7:0]    col_data_q, col_data_d;
  logic          frame_done_q, frame_done_d;
  logic          swap;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    swap    = 1'b0;
    if (!en) begin
      state_d = S_BLANK;
      row_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_BLANK: begin
          if (BLANK == 0 || cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            row_d   = row_q + 3'd1;
            swap    = (row_q == 3'd7);
            state_d = (BLANK == 0) ? S_DRIVE : S_BLANK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_BLANK;
      endcase
    end
  end

  // Data arriving on the swap edge goes straight to the front and supersedes any pending frame.
  always_comb begin
    front_d   = front_q;
    back_d    = back_q;
    pending_d = pending_q;
    dropped_d = dropped_q;
    if (swap) begin
      if (gen_valid) begin
        front_d = grid_in;
      end else if (pending_q) begin
        front_d = back_q;
      end
      pending_d = 1'b0;
    end else if (gen_valid) begin
      back_d    = grid_in;
      pending_d = 1'b1;
      if (pending_q) dropped_d = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    row_sel_d    = 8'h00;
    col_data_d   = 8'h00;
    frame_done_d = swap;
    if (state_d == S_DRIVE) begin
      row_sel_d  = 8'(1) << row_d;
      col_data_d = front_d[{row_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BLANK;
      row_q        <= 3'd0;
      cnt_q        <= '0;
      front_q      <= 64'd0;
      back_q       <= 64'd0;
      pending_q    <= 1'b0;
      dropped_q    <= 1'b0;
      row_sel_q    <= 8'h00;
      col_data_q   <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      front_q      <= front_d;
      back_q       <= back_d;
      pending_q    <= pending_d;
      dropped_q    <= dropped_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign frame_done = frame_done_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_grid_scan_driver.sv
// Directed bench for grid_scan_driver at DWELL=4, BLANK=2 (48-cycle frame).
// Expected scan outputs come from frame phase arithmetic plus a small buffer model.
module tb_grid_scan_driver;

  localparam int DW = 4;
  localparam int BL = 2;
  localparam int ROWP = DW + BL;
  localparam int FRAME = 8 * ROWP;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] grid_in;
  logic        gen_valid;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;
  logic        dropped;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int edge_cnt = 0;
  int last_fd = -1;
  logic [63:0] m_front, m_back;
  logic        m_pend, m_drop;

  localparam logic [63:0] G1 = 64'h0102040810204080;
  localparam logic [63:0] GA = 64'h11111111111111AA;
  localparam logic [63:0] GC = 64'h22222222222222CC;
  localparam logic [63:0] GA2 = 64'h3333333333333333;
  localparam logic [63:0] GB = 64'h445566778899AABB;

  grid_scan_driver #(.DWELL(DW), .BLANK(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .grid_in(grid_in), .gen_valid(gen_valid),
    .row_sel(row_sel), .col_data(col_data), .frame_done(frame_done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_front = '0; m_back = '0; m_pend = 1'b0; m_drop = 1'b0;
    n = 0; last_fd = -1;
  endtask

  task automatic tick(input logic gv, input logic [63:0] d);
    logic en_s, sw;
    int p, r, k;
    logic [7:0] e_rs, e_cd;
    gen_valid = gv;
    grid_in = d;
    @(posedge clk);
    edge_cnt++;
    en_s = en;
    sw = 1'b0;
    if (!en_s) begin
      n = 0;
      last_fd = -1;
    end else begin
      n++;
      sw = ((n % FRAME) == 0);
    end
    if (sw) begin
      if (gv) m_front = d;
      else if (m_pend) m_front = m_back;
      m_pend = 1'b0;
    end else if (gv) begin
      if (m_pend) m_drop = 1'b1;
      m_back = d;
      m_pend = 1'b1;
    end
    #1;
    gen_valid = 1'b0;
    p = n % FRAME;
    r = p / ROWP;
    k = p % ROWP;
    e_rs = 8'h00;
    e_cd = 8'h00;
    if (en_s && k >= BL) begin
      e_rs = 8'(1) << r;
      e_cd = m_front[r*8 +: 8];
    end
    chk("row_sel", 64'(row_sel), 64'(e_rs));
    chk("col_data", 64'(col_data), 64'(e_cd));
    chk("frame_done", 64'(frame_done), 64'(sw));
    chk("dropped", 64'(dropped), 64'(m_drop));
    chk("onehot", 64'($countones(row_sel) <= 1), 64'd1);
    if (frame_done) begin
      if (last_fd >= 0) chk("fd_period", 64'(edge_cnt - last_fd), 64'(FRAME));
      last_fd = edge_cnt;
    end
  endtask

  // Stops just before the edge that lands on frame phase p.
  task automatic run_until_phase(input int p);
    for (int i = 0; i < 2 * FRAME && ((n + 1) % FRAME) != p; i++) tick(1'b0, 64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; gen_valid = 1'b0; grid_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_row_sel", 64'(row_sel), 64'd0);
    chk("rst_col_data", 64'(col_data), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    rst = 1'b0;

    // Generation loaded during frame 1, shown in frame 2.
    tick(1'b0, 0); tick(1'b0, 0);
    chk("first_drive", 64'(row_sel), 64'h01);
    tick(1'b1, G1);
    run_until_phase(2); tick(1'b0, 0);
    chk("s1_row0_sel", 64'(row_sel), 64'h01);
    chk("s1_row0_col", 64'(col_data), 64'h80);
    run_until_phase(44); tick(1'b0, 0);
    chk("s1_row7_sel", 64'(row_sel), 64'h80);
    chk("s1_row7_col", 64'(col_data), 64'h01);

    // Pending A superseded by C arriving on the swap edge.
    run_until_phase(10); tick(1'b1, GA);
    run_until_phase(0); tick(1'b1, GC);
    chk("s4_dropped", 64'(dropped), 64'd0);
    run_until_phase(2); tick(1'b0, 0);
    chk("s4_row0_col", 64'(col_data), 64'hCC);
    run_until_phase(2); tick(1'b0, 0);
    chk("s4_hold_col", 64'(col_data), 64'hCC);

    // Two generations within one frame: second wins, overwrite flagged.
    run_until_phase(8); tick(1'b1, GA2);
    run_until_phase(30); tick(1'b1, GB);
    chk("s3_dropped", 64'(dropped), 64'd1);
    run_until_phase(2); tick(1'b0, 0);
    chk("s3_row0_col", 64'(col_data), 64'hBB);
    run_until_phase(26); tick(1'b0, 0);
    chk("s3_row4_col", 64'(col_data), 64'h77);

    // Enable dropped mid-row 3 for five edges.
    run_until_phase(21); tick(1'b0, 0);
    chk("s5_row3_sel", 64'(row_sel), 64'h08);
    en = 1'b0;
    tick(1'b0, 0);
    chk("s5_off_sel", 64'(row_sel), 64'h00);
    chk("s5_off_col", 64'(col_data), 64'h00);
    repeat (4) tick(1'b0, 0);
    en = 1'b1;
    tick(1'b0, 0);
    chk("s5_blank", 64'(row_sel), 64'h00);
    tick(1'b0, 0);
    chk("s5_restart_row0", 64'(row_sel), 64'h01);
    repeat (FRAME + 4) tick(1'b0, 0);

    // Asynchronous reset in the middle of a driven row.
    run_until_phase(14); tick(1'b0, 0);
    chk("s6_pre_sel", 64'(row_sel), 64'h04);
    chk("s6_pre_drop", 64'(dropped), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("s6_async_sel", 64'(row_sel), 64'h00);
    chk("s6_async_col", 64'(col_data), 64'h00);
    chk("s6_async_drop", 64'(dropped), 64'd0);
    model_reset();
    #2 rst = 1'b0;
    tick(1'b0, 0);
    chk("s6_post_blank", 64'(row_sel), 64'h00);
    repeat (FRAME + 6) tick(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
